// File: rtl/aoi_sweep_ctrl_pkg.sv
// Shared state encodings, signature constants and the signature step function
// used by the AOI sweep controller and its signature register.
package aoi_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [15:0] SIG_SEED = 16'hFFFF;

    function automatic logic [15:0] sig_step(input logic [15:0] sig,
                                             input logic        din,
                                             input logic [15:0] poly);
        logic fb;
        fb = sig[15] ^ din;
        return {sig[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/aoi_sweep_ctrl_if.sv
// Handshake, cell drive and result bus between the sweep controller (slave)
// and whatever starts runs and hosts the AOI cell (master).
interface aoi_sweep_ctrl_if #(
    parameter int N = 11
);
    logic         START;
    logic         MODE;
    logic         ABORT;
    logic [N-1:0] VEC_IN;
    logic [N-1:0] AOI_IN;
    logic         AOI_Y;
    logic         BUSY;
    logic         DONE;
    logic [N:0]   ONES_CNT;
    logic [15:0]  SIG;

    modport master (
        output START, MODE, ABORT, VEC_IN, AOI_Y,
        input  AOI_IN, BUSY, DONE, ONES_CNT, SIG
    );

    modport slave (
        input  START, MODE, ABORT, VEC_IN, AOI_Y,
        output AOI_IN, BUSY, DONE, ONES_CNT, SIG
    );
endinterface

// File: rtl/sig_lfsr16.sv
// Serial 16-bit signature register: seed load has priority over a shift of din.
module sig_lfsr16
    import aoi_sweep_ctrl_pkg::*;
#(
    parameter logic [15:0] POLY = DEF_POLY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic        shift_en,
    input  logic        din,
    output logic [15:0] sig
);

    logic [15:0] sig_q;
    logic [15:0] sig_d;

    // Next signature value
    always_comb begin
        sig_d = sig_q;
        if (seed_load) begin
            sig_d = SIG_SEED;
        end else if (shift_en) begin
            sig_d = sig_step(sig_q, din, POLY);
        end else begin
            sig_d = sig_q;
        end
    end

    // Signature register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= SIG_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/aoi_sweep_ctrl.sv
// Sweep sequencer for an AOI_6 cell: applies vectors, waits a settle time,
// samples Y and compresses the response into a ones count and a signature.
module aoi_sweep_ctrl
    import aoi_sweep_ctrl_pkg::*;
#(
    parameter int          N      = 11,
    parameter int          SETTLE = 2,
    parameter logic [15:0] POLY   = DEF_POLY
) (
    input logic               CLK,
    input logic               RST,
    aoi_sweep_ctrl_if.slave   bus
);

    localparam logic [3:0]   SETTLE_LD = 4'(SETTLE - 1);
    localparam logic [N-1:0] VEC_LAST  = {N{1'b1}};
    localparam logic [N-1:0] VEC_ONE   = {{(N-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] vec_q, vec_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [N:0]   ones_q, ones_d;
    logic         mode_q, mode_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         seed_load;
    logic         shift_en;
    logic [15:0]  sig_s;

    // Next-state, counter and handshake logic
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        ones_d    = ones_q;
        mode_d    = mode_q;
        busy_d    = busy_q;
        done_d    = done_q;
        seed_load = 1'b0;
        shift_en  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.START) begin
                    mode_d    = bus.MODE;
                    vec_d     = bus.MODE ? bus.VEC_IN : {N{1'b0}};
                    ones_d    = {(N+1){1'b0}};
                    seed_load = 1'b1;
                    cnt_d     = SETTLE_LD;
                    state_d   = ST_SETTLE;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                end else begin
                    busy_d = 1'b0;
                    // DONE trails entry into ST_DONE by one cycle
                    done_d = (state_q == ST_DONE);
                end
            end
            ST_SETTLE: begin
                if (bus.ABORT) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (bus.ABORT) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    shift_en = 1'b1;
                    ones_d   = ones_q + {{N{1'b0}}, bus.AOI_Y};
                    if (mode_q || (vec_q == VEC_LAST)) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                    end else begin
                        vec_d   = vec_q + VEC_ONE;
                        cnt_d   = SETTLE_LD;
                        state_d = ST_SETTLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // Controller state registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            vec_q   <= {N{1'b0}};
            cnt_q   <= 4'd0;
            ones_q  <= {(N+1){1'b0}};
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    sig_lfsr16 #(
        .POLY (POLY)
    ) u_sig (
        .clk       (CLK),
        .rst       (RST),
        .seed_load (seed_load),
        .shift_en  (shift_en),
        .din       (bus.AOI_Y),
        .sig       (sig_s)
    );

    assign bus.AOI_IN   = vec_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.ONES_CNT = ones_q;
    assign bus.SIG      = sig_s;

endmodule

// File: tb/tb_aoi_sweep_ctrl.sv
// Scoreboard bench for aoi_sweep_ctrl: stimulus queues expected run results,
// a monitor compares them when DONE rises.
module tb_aoi_sweep_ctrl;

    localparam int          N    = 11;
    localparam logic [15:0] POLY = 16'h1021;

    typedef struct {
        logic [N:0]   ones;
        logic [15:0]  sig;
        logic [N-1:0] aoi;
        int           lat;
        int           busy;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         busy_cnt = 0;
    logic       done_prev = 1'b0;
    logic [1:0] ysel = 2'd0;
    exp_t       sb[$];

    aoi_sweep_ctrl_if #(.N(N)) bus();

    aoi_sweep_ctrl #(.N(N), .SETTLE(2), .POLY(POLY)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // AOI_6 model: Y = ~(AB | CD | EF | GH | IJ | K)
    function automatic logic aoi6(input logic [N-1:0] v);
        return ~((v[10] & v[9]) | (v[8] & v[7]) | (v[6] & v[5]) |
                 (v[4] & v[3]) | (v[2] & v[1]) | v[0]);
    endfunction

    function automatic logic y_of(input logic [1:0] sel, input logic [N-1:0] v);
        case (sel)
            2'd1:    return ^v;
            2'd2:    return aoi6(v);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] sig_next(input logic [15:0] s, input logic y);
        logic fb;
        fb = s[15] ^ y;
        return {s[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    endfunction

    assign bus.AOI_Y = y_of(ysel, bus.AOI_IN);

    task automatic model_run(input logic [1:0] sel, input int first, input int last,
                             output logic [N:0] ones, output logic [15:0] sig);
        logic y;
        ones = '0;
        sig  = 16'hFFFF;
        for (int v = first; v <= last; v++) begin
            y    = y_of(sel, N'(v));
            ones = ones + {{N{1'b0}}, y};
            sig  = sig_next(sig, y);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [N:0] ones, input logic [15:0] sig,
                            input logic [N-1:0] aoi, input int lat, input int busy);
        exp_t e;
        e.ones = ones; e.sig = sig; e.aoi = aoi; e.lat = lat; e.busy = busy;
        sb.push_back(e);
    endtask

    task automatic start_run(input logic mode, input logic [N-1:0] vec, input logic abort);
        @(negedge CLK);
        bus.START = 1'b1; bus.MODE = mode; bus.VEC_IN = vec; bus.ABORT = abort;
        @(posedge CLK);
        #1;
        bus.START = 1'b0; bus.ABORT = 1'b0;
        start_cyc = cyc;
        busy_cnt  = 0;
    endtask

    task automatic wait_q(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge CLK);
            n++;
        end
        chk(name, sb.size(), 0);
    endtask

    // Monitor: count BUSY cycles and score each completed run on DONE rising
    always @(negedge CLK) begin
        exp_t e;
        if (bus.BUSY === 1'b1) busy_cnt = busy_cnt + 1;
        if (bus.DONE === 1'b1 && done_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sb.pop_front();
                chk("done_ones_cnt", bus.ONES_CNT, e.ones);
                chk("done_sig", bus.SIG, e.sig);
                chk("done_aoi_in", bus.AOI_IN, e.aoi);
                chk("done_latency", cyc - start_cyc, e.lat);
                chk("busy_cycles", busy_cnt, e.busy);
            end
        end
        done_prev = bus.DONE;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N:0]  o;
        logic [15:0] s;
        bus.START = 1'b0; bus.MODE = 1'b0; bus.ABORT = 1'b0; bus.VEC_IN = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_aoi_in", bus.AOI_IN, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_done", bus.DONE, 0);
        chk("rst_ones", bus.ONES_CNT, 0);
        chk("rst_sig", bus.SIG, 16'hFFFF);

        // Exhaustive sweep, Y tied low
        ysel = 2'd0;
        model_run(2'd0, 0, 2047, o, s);
        push_exp(12'd0, s, 11'h7FF, 6145, 6144);
        start_run(1'b0, 11'h000, 1'b0);
        wait_q("sweep_zero_done", 7000);

        // Exhaustive sweep, parity response
        ysel = 2'd1;
        model_run(2'd1, 0, 2047, o, s);
        push_exp(12'd1024, s, 11'h7FF, 6145, 6144);
        start_run(1'b0, 11'h000, 1'b0);
        wait_q("sweep_parity_done", 7000);

        // Single vector through the AOI_6 model
        ysel = 2'd2;
        model_run(2'd2, 24, 24, o, s);
        push_exp(o, s, 11'h018, 4, 3);
        start_run(1'b1, 11'h018, 1'b0);
        chk("single_aoi_in", bus.AOI_IN, 11'h018);
        chk("single_busy", bus.BUSY, 1);
        wait_q("single_done", 20);

        // Abort seen at edge t+100: vectors 0..32 sampled, vector 33 driven
        ysel = 2'd1;
        start_run(1'b0, 11'h000, 1'b0);
        repeat (99) @(posedge CLK);
        #1 bus.ABORT = 1'b1;
        @(posedge CLK);
        #1 bus.ABORT = 1'b0;
        model_run(2'd1, 0, 32, o, s);
        chk("abort_busy", bus.BUSY, 0);
        chk("abort_done", bus.DONE, 0);
        chk("abort_ones", bus.ONES_CNT, o);
        chk("abort_sig", bus.SIG, s);
        chk("abort_aoi_in", bus.AOI_IN, 11'd33);
        repeat (5) @(posedge CLK);
        #1;
        chk("abort_hold_ones", bus.ONES_CNT, o);
        chk("abort_hold_sig", bus.SIG, s);
        chk("abort_hold_busy", bus.BUSY, 0);
        model_run(2'd1, 0, 2047, o, s);
        push_exp(12'd1024, s, 11'h7FF, 6145, 6144);
        start_run(1'b0, 11'h000, 1'b0);
        chk("restart_sig_seed", bus.SIG, 16'hFFFF);
        chk("restart_ones_clear", bus.ONES_CNT, 0);
        wait_q("restart_done", 7000);

        // START while busy ignored; START+ABORT while busy aborts at edge t+20
        start_run(1'b0, 11'h000, 1'b0);
        repeat (9) @(posedge CLK);
        #1 bus.START = 1'b1;
        @(posedge CLK);
        #1 bus.START = 1'b0;
        repeat (9) @(posedge CLK);
        #1 begin bus.START = 1'b1; bus.ABORT = 1'b1; end
        @(posedge CLK);
        #1 begin bus.START = 1'b0; bus.ABORT = 1'b0; end
        model_run(2'd1, 0, 5, o, s);
        chk("busy_start_abort_busy", bus.BUSY, 0);
        chk("busy_start_abort_done", bus.DONE, 0);
        chk("busy_start_abort_aoi", bus.AOI_IN, 11'd6);
        chk("busy_start_abort_ones", bus.ONES_CNT, o);
        chk("busy_start_abort_sig", bus.SIG, s);

        // START+ABORT in DONE starts a new run
        ysel = 2'd2;
        model_run(2'd2, 1024, 1024, o, s);
        push_exp(12'd1, s, 11'h400, 4, 3);
        start_run(1'b1, 11'h400, 1'b0);
        wait_q("single_a_done", 20);
        model_run(2'd2, 3, 3, o, s);
        push_exp(12'd0, s, 11'h003, 4, 3);
        start_run(1'b1, 11'h003, 1'b1);
        chk("done_start_abort_busy", bus.BUSY, 1);
        wait_q("done_start_abort_run", 20);

        // Asynchronous reset in the middle of SETTLE
        ysel = 2'd1;
        start_run(1'b0, 11'h000, 1'b0);
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        chk("arst_aoi_in", bus.AOI_IN, 0);
        chk("arst_busy", bus.BUSY, 0);
        chk("arst_done", bus.DONE, 0);
        chk("arst_ones", bus.ONES_CNT, 0);
        chk("arst_sig", bus.SIG, 16'hFFFF);
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("post_rst_busy", bus.BUSY, 0);
        chk("post_rst_aoi_in", bus.AOI_IN, 0);
        ysel = 2'd2;
        model_run(2'd2, 2047, 2047, o, s);
        push_exp(12'd0, s, 11'h7FF, 4, 3);
        start_run(1'b1, 11'h7FF, 1'b0);
        wait_q("post_rst_run", 20);

        repeat (3) @(posedge CLK);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aoi_sweep_ctrl.md
# aoi_sweep_ctrl

Sequencer that drives an AOI_6 and-or-invert cell through a test sweep and compresses its response on chip. It applies input vectors to the cell, waits a programmable settle time, samples Y, and keeps a running ones count and a 16-bit serial signature. It sits beside the AOI_6 instance in the microarchitecture circuits bench and gives a self-checking characterisation path with a START/BUSY/DONE handshake.

## Interface
Parameters:
- N, 11, number of AOI inputs driven (AOI_IN width).
- SETTLE, 2, cycles each vector is held before Y is sampled (legal range 1 to 15).
- POLY, 16'h1021, signature feedback polynomial.

Ports:
- CLK  in  1  single clock; all state changes on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  one-cycle start pulse; honoured only in IDLE or DONE.
- MODE  in  1  0 = exhaustive sweep of all 2^N vectors; 1 = single vector taken from VEC_IN.
- ABORT  in  1  terminates a run in progress.
- VEC_IN  in  N  vector used when MODE=1; sampled on the START cycle.
- AOI_IN  out  N  registered drive to the cell, {A,B,C,D,E,F,G,H,I,J,K} MSB first (A=bit10, K=bit0).
- AOI_Y  in  1  cell output Y.
- BUSY  out  1  high in SETTLE and SAMPLE.
- DONE  out  1  high in DONE state until the next START or RST.
- ONES_CNT  out  N+1  number of samples with Y=1.
- SIG  out  16  serial signature of the Y stream.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE. Encodings live in the shared header.
- IDLE/DONE with START=1:
  - Latch MODE.
  - Set the vector register to 0 (MODE=0) or VEC_IN (MODE=1), and drive AOI_IN from it on the next edge.
  - Clear ONES_CNT to 0 and seed SIG to 16'hFFFF.
  - Load the settle counter with SETTLE-1 and go to SETTLE.
- SETTLE: AOI_IN is held. Decrement the counter; at 0, go to SAMPLE.
- SAMPLE:
  - Capture AOI_Y. ONES_CNT += AOI_Y.
  - SIG update: fb = SIG[15]^AOI_Y; SIG <= {SIG[14:0],1'b0} ^ (fb ? POLY : 0).
  - If MODE=1, or the vector equals 2^N-1: go to DONE.
  - Otherwise: vector += 1, drive the new AOI_IN, reload the counter, and go to SETTLE.
- DONE: outputs are held, BUSY=0, DONE=1.
- ABORT in SETTLE or SAMPLE: go to IDLE on the next edge. No sample is taken that cycle, and DONE stays 0. ONES_CNT, SIG and AOI_IN hold their partial values.
- ABORT in IDLE or DONE is ignored.
- ABORT and START in the same cycle: ABORT wins when BUSY; START wins otherwise.
- START while BUSY is ignored.
- The vector counter never wraps. The terminal vector ends the run.
- ONES_CNT is N+1 bits wide, so it cannot overflow (maximum value 2^N).

## Timing
- Reset values:
  - State = IDLE.
  - AOI_IN=0, BUSY=0, DONE=0.
  - ONES_CNT=0, SIG=16'hFFFF.
- RST asserted mid-run returns the block to these values immediately, independent of CLK.
- START seen at edge t: AOI_IN is valid and BUSY=1 from t+1.
- Each vector occupies SETTLE cycles in SETTLE plus 1 cycle in SAMPLE.
- The first sample is taken at edge t+SETTLE+1.
- DONE rises 2^N·(SETTLE+1)+1 cycles after the START edge in exhaustive mode. With defaults that is 6145.
- In single mode DONE rises SETTLE+2 cycles after the START edge (4 with defaults).
- AOI_Y is treated as combinational from AOI_IN. SETTLE must cover the cell path.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared header aoi_ctrl_defs.vh holds:
  - the state encodings (2-bit: IDLE=0, SETTLE=1, SAMPLE=2, DONE=3);
  - the default POLY;
  - the SIG seed 16'hFFFF.
- One sub-module, sig_lfsr16: serial signature register with seed load, shift-enable and data-in ports, parameterised by POLY.
- Top level holds the FSM, the vector counter, the settle counter and the ones counter. AOI_6 is instantiated by the bench, not inside this block.

## Test plan
- AOI_Y tied 0, MODE=0, START: DONE at cycle 6145, ONES_CNT=0, AOI_IN holds 11'h7FF. SIG equals the model value for 2048 zero shifts from 16'hFFFF.
- AOI_Y = ^AOI_IN (parity model), MODE=0: ONES_CNT=1024, BUSY high for exactly 6144 cycles, SIG matches the bench model.
- Real AOI_6, MODE=1, VEC_IN=11'h018 (G=H=1, all else 0): AOI_IN=11'h018 one cycle after START, DONE 4 cycles after START. ONES_CNT equals the model's Y for that vector.
- ABORT asserted at cycle 100 of a sweep: IDLE next cycle, DONE=0, ONES_CNT and SIG frozen. A following START reseeds (SIG=16'hFFFF, ONES_CNT=0) and completes normally.
- START pulsed while BUSY, and START+ABORT together while BUSY: no restart, abort taken. START+ABORT in DONE: a new run starts.
- RST asserted asynchronously mid-SETTLE: all outputs at their reset values before the next CLK edge. The FSM is in IDLE after RST deasserts.
